// File: rtl/mac_sched.sv
// Product-scanning operand scheduler: issues NW*NW word pairs in column order
// to a multi-DSP MAC and delays the column tags by the MAC latency.
//
// state | meaning
// IDLE  | no operation in flight, ready for an operand pair
// ISSUE | emitting one word pair per cycle from the latched operands
module mac_sched #(
    parameter int W   = 60,
    parameter int NW  = 4,
    parameter int LAT = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NW*W-1:0]            in_x,
    input  logic [NW*W-1:0]            in_y,
    output logic                       out_valid,
    output logic [W-1:0]               out_a,
    output logic [W-1:0]               out_b,
    output logic [((NW > 1) ? $clog2(2*NW-1) : 1)-1:0] out_col,
    output logic                       out_first,
    output logic                       out_last,
    output logic                       out_done,
    output logic                       tag_valid,
    output logic [((NW > 1) ? $clog2(2*NW-1) : 1)-1:0] tag_col,
    output logic                       tag_first,
    output logic                       tag_last,
    output logic                       tag_done
);

    localparam int CW = (NW > 1) ? $clog2(2*NW-1) : 1;
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;
    localparam int TW = CW + 4;
    localparam int KMAX = 2*NW - 2;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t          state;
    logic [NW*W-1:0] x_reg;
    logic [NW*W-1:0] y_reg;
    logic [IW-1:0]   i_cur;
    logic            xfer;

    int              kc;
    int              ic;
    int              kn;
    int              in_n;
    logic [W-1:0]    a_nxt;
    logic [W-1:0]    b_nxt;
    logic            first_nxt;
    logic            last_nxt;
    logic            done_nxt;

    function automatic int col_lo(input int k);
        return (k > NW-1) ? k - NW + 1 : 0;
    endfunction

    function automatic int col_hi(input int k);
        return (k < NW-1) ? k : NW - 1;
    endfunction

    assign in_ready = !rst && (state == IDLE || (state == ISSUE && out_done));
    assign xfer     = in_valid && in_ready;

    // Successor of the beat currently on the outputs, read from the latched operands.
    always_comb begin
        kc = int'(out_col);
        ic = int'(i_cur);
        if (ic == col_hi(kc)) begin
            kn   = kc + 1;
            in_n = col_lo(kc + 1);
        end else begin
            kn   = kc;
            in_n = ic + 1;
        end
        a_nxt     = x_reg[W*in_n +: W];
        b_nxt     = y_reg[W*(kn - in_n) +: W];
        first_nxt = (in_n == col_lo(kn));
        last_nxt  = (in_n == col_hi(kn));
        done_nxt  = (kn == KMAX) && last_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
            i_cur     <= '0;
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_col   <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            out_done  <= 1'b0;
        end else if (xfer) begin
            // Beat 0 comes straight from the inputs so the pair arrives with no bubble.
            state     <= ISSUE;
            x_reg     <= in_x;
            y_reg     <= in_y;
            i_cur     <= '0;
            out_valid <= 1'b1;
            out_a     <= in_x[W-1:0];
            out_b     <= in_y[W-1:0];
            out_col   <= '0;
            out_first <= 1'b1;
            out_last  <= 1'b1;
            out_done  <= (NW == 1);
        end else begin
            case (state)
                ISSUE: begin
                    if (out_done) begin
                        state     <= IDLE;
                        i_cur     <= '0;
                        out_valid <= 1'b0;
                        out_a     <= '0;
                        out_b     <= '0;
                        out_col   <= '0;
                        out_first <= 1'b0;
                        out_last  <= 1'b0;
                        out_done  <= 1'b0;
                    end else begin
                        i_cur     <= IW'(in_n);
                        out_valid <= 1'b1;
                        out_a     <= a_nxt;
                        out_b     <= b_nxt;
                        out_col   <= CW'(kn);
                        out_first <= first_nxt;
                        out_last  <= last_nxt;
                        out_done  <= done_nxt;
                    end
                end
                default: begin
                    state     <= IDLE;
                    i_cur     <= '0;
                    out_valid <= 1'b0;
                    out_a     <= '0;
                    out_b     <= '0;
                    out_col   <= '0;
                    out_first <= 1'b0;
                    out_last  <= 1'b0;
                    out_done  <= 1'b0;
                end
            endcase
        end
    end

    logic [TW-1:0] tag_in;
    logic [TW-1:0] tag_out;

    assign tag_in = {out_valid, out_col, out_first, out_last, out_done};

    generate
        if (LAT == 0) begin : g_no_lat
            assign tag_out = tag_in;
        end else begin : g_lat
            logic [TW-1:0] pipe [LAT];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int s = 0; s < LAT; s++) pipe[s] <= '0;
                end else begin
                    pipe[0] <= tag_in;
                    for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
                end
            end

            assign tag_out = pipe[LAT-1];
        end
    endgenerate

    assign {tag_valid, tag_col, tag_first, tag_last, tag_done} = tag_out;

endmodule

// File: tb/tb_mac_sched.sv
// Directed bench for mac_sched: NW=4/LAT=3 instance plus an NW=1/LAT=0 instance.
module tb_mac_sched;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // NW=4, LAT=3 instance
    logic         in_valid, in_ready;
    logic [239:0] in_x, in_y;
    logic         out_valid, out_first, out_last, out_done;
    logic [59:0]  out_a, out_b;
    logic [2:0]   out_col, tag_col;
    logic         tag_valid, tag_first, tag_last, tag_done;

    mac_sched #(.W(60), .NW(4), .LAT(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .out_valid(out_valid), .out_a(out_a),
        .out_b(out_b), .out_col(out_col), .out_first(out_first),
        .out_last(out_last), .out_done(out_done), .tag_valid(tag_valid),
        .tag_col(tag_col), .tag_first(tag_first), .tag_last(tag_last),
        .tag_done(tag_done)
    );

    // NW=1, LAT=0 instance
    logic         in_valid1, in_ready1;
    logic [59:0]  in_x1, in_y1;
    logic         out_valid1, out_first1, out_last1, out_done1;
    logic [59:0]  out_a1, out_b1;
    logic [0:0]   out_col1, tag_col1;
    logic         tag_valid1, tag_first1, tag_last1, tag_done1;

    mac_sched #(.W(60), .NW(1), .LAT(0)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_x(in_x1), .in_y(in_y1), .out_valid(out_valid1), .out_a(out_a1),
        .out_b(out_b1), .out_col(out_col1), .out_first(out_first1),
        .out_last(out_last1), .out_done(out_done1), .tag_valid(tag_valid1),
        .tag_col(tag_col1), .tag_first(tag_first1), .tag_last(tag_last1),
        .tag_done(tag_done1)
    );

    logic [126:0] obs_out;
    logic [6:0]   obs_tag;
    logic [124:0] obs_out1;
    logic [4:0]   obs_tag1;
    assign obs_out  = {out_valid, out_a, out_b, out_col, out_first, out_last, out_done};
    assign obs_tag  = {tag_valid, tag_col, tag_first, tag_last, tag_done};
    assign obs_out1 = {out_valid1, out_a1, out_b1, out_col1, out_first1, out_last1, out_done1};
    assign obs_tag1 = {tag_valid1, tag_col1, tag_first1, tag_last1, tag_done1};

    // Hand-derived column schedule for NW=4
    int          col_tab [16] = '{0,1,1,2,2,2,3,3,3,3,4,4,4,5,5,6};
    int          i_tab   [16] = '{0,0,1,0,1,2,0,1,2,3,1,2,3,2,3,3};
    logic [15:0] first_m = 16'hA44B;
    logic [15:0] last_m  = 16'hD225;

    logic [239:0] x1 = {60'd4, 60'd3, 60'd2, 60'd1};
    logic [239:0] y1 = {60'd64, 60'd48, 60'd32, 60'd16};
    logic [239:0] x2 = {60'd8, 60'd7, 60'd6, 60'd5};
    logic [239:0] y2 = {60'd4, 60'd3, 60'd2, 60'd1};
    logic [239:0] xg = {4{60'h5A5_A5A5_A5A5_A5A5}};
    logic [239:0] yg = {4{60'h0F0_F0F0_F0F0_F0F0}};

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [126:0] exp_out(input int n, input logic [239:0] x, input logic [239:0] y);
        int i, j;
        if (n < 0 || n > 15) return '0;
        i = i_tab[n];
        j = col_tab[n] - i;
        return {1'b1, x[60*i +: 60], y[60*j +: 60], 3'(col_tab[n]),
                first_m[n], last_m[n], (n == 15)};
    endfunction

    function automatic logic [6:0] exp_tag(input int n);
        if (n < 0 || n > 15) return '0;
        return {1'b1, 3'(col_tab[n]), first_m[n], last_m[n], (n == 15)};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_x = '0; in_y = '0;
        in_valid1 = 1'b0; in_x1 = '0; in_y1 = '0;
        repeat (2) @(negedge clk);
        check("rst_out", obs_out, '0);
        check("rst_tag", obs_tag, '0);
        check("rst_rdy", in_ready, 1'b0);
        rst = 1'b0;
        #1;
        check("idle_rdy", in_ready, 1'b1);

        // Single operation
        @(negedge clk);
        in_valid = 1'b1; in_x = x1; in_y = y1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            check($sformatf("s1_out%0d", c), obs_out, exp_out(c, x1, y1));
            check($sformatf("s1_tag%0d", c), obs_tag, exp_tag(c - 3));
            check($sformatf("s1_rdy%0d", c), in_ready, (c >= 15));
            @(negedge clk);
        end

        // Back-to-back with in_valid held high
        in_valid = 1'b1; in_x = x1; in_y = y1;
        @(negedge clk);
        in_x = x2; in_y = y2;
        for (int c = 0; c < 36; c++) begin
            logic [126:0] eo;
            int n;
            if (c < 16) eo = exp_out(c, x1, y1);
            else eo = exp_out(c - 16, x2, y2);
            n = c - 3;
            check($sformatf("b2b_out%0d", c), obs_out, eo);
            check($sformatf("b2b_tag%0d", c), obs_tag, (n >= 0 && n < 32) ? exp_tag(n % 16) : 7'd0);
            check($sformatf("b2b_rdy%0d", c), in_ready, (c == 15 || c >= 31));
            if (c == 16) in_valid = 1'b0;
            @(negedge clk);
        end

        // Reset during beat 7
        in_valid = 1'b1; in_x = x1; in_y = y1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            check($sformatf("rst_pre_out%0d", c), obs_out, exp_out(c, x1, y1));
            if (c < 7) @(negedge clk);
        end
        rst = 1'b1;
        #1;
        check("rst_mid_out", obs_out, '0);
        check("rst_mid_tag", obs_tag, '0);
        check("rst_mid_rdy", in_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_post_rdy", in_ready, 1'b1);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("rst_post_out%0d", c), obs_out, '0);
            check($sformatf("rst_post_tag%0d", c), obs_tag, '0);
            @(negedge clk);
        end

        // in_valid pulse mid-operation is ignored
        in_valid = 1'b1; in_x = x1; in_y = y1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            check($sformatf("ign_out%0d", c), obs_out, exp_out(c, x1, y1));
            check($sformatf("ign_tag%0d", c), obs_tag, exp_tag(c - 3));
            check($sformatf("ign_rdy%0d", c), in_ready, (c >= 15));
            if (c == 4) begin in_valid = 1'b1; in_x = xg; in_y = yg; end
            if (c == 5) in_valid = 1'b0;
            @(negedge clk);
        end

        // NW=1, LAT=0
        in_valid1 = 1'b1; in_x1 = 60'd5; in_y1 = 60'd7;
        check("n1_rdy_idle", in_ready1, 1'b1);
        @(negedge clk);
        in_valid1 = 1'b0;
        check("n1_out", obs_out1, {1'b1, 60'd5, 60'd7, 1'b0, 1'b1, 1'b1, 1'b1});
        check("n1_tag", obs_tag1, 5'b1_0_111);
        check("n1_rdy_done", in_ready1, 1'b1);
        @(negedge clk);
        check("n1_out_idle", obs_out1, '0);
        check("n1_tag_idle", obs_tag1, '0);
        check("n1_rdy_back", in_ready1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
